// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller:
// op encodings, fixed latencies, FSM states and small decode helpers.
package md_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MTHI  = 3'b110,
        OP_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL_RUN = 2'b01,
        ST_DIV_RUN = 2'b10
    } md_state_e;

    localparam int unsigned CNT_W   = 4;
    localparam logic [3:0]  MUL_LAT = 4'd5;
    localparam logic [3:0]  DIV_LAT = 4'd10;

    // True for ops that launch a multi-cycle datapath operation.
    function automatic logic is_start_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // True for the multiply subset of the start ops.
    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    // True for any MD-class op that needs the unit (everything but none/reserved).
    function automatic logic is_md_op(input logic [2:0] op);
        return (op != OP_NONE) && (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Loadable down-counter tracking remaining MD latency; saturates at zero.
module md_lat_cnt
    import md_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Counter register: load wins over decrement, never wraps below zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/sequencing control for the multiply/divide unit: accepts MD ops
// from the E stage, times fixed-latency runs, stalls D and commits HI/LO.
module md_issue_ctrl
    import md_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic [2:0] e_op,
    input  logic       e_div_zero,
    input  logic       e_flush,
    input  logic       d_uses_md,
    output logic       md_start,
    output logic [2:0] md_op,
    output logic       mt_lo_we,
    output logic       mt_hi_we,
    output logic       hilo_we,
    output logic       busy,
    output logic       stall_d,
    output logic       issue_err,
    output logic [3:0] cnt
);

    md_state_e        r_state;
    md_state_e        w_next_state;
    logic [2:0]       r_md_op;
    logic             r_div_zero;
    logic             w_busy;
    logic             w_legal_start;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt;

    md_lat_cnt u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the issued op and divide-by-zero flag; clear when the run retires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_md_op    <= 3'b000;
            r_div_zero <= 1'b0;
        end else if (w_legal_start) begin
            r_md_op    <= e_op;
            r_div_zero <= e_div_zero && !is_mul_op(e_op);
        end else if (w_busy && w_cnt_zero) begin
            r_md_op    <= 3'b000;
            r_div_zero <= 1'b0;
        end else begin
            r_md_op    <= r_md_op;
            r_div_zero <= r_div_zero;
        end
    end

    // Next-state and output decode; every pulse is gated off while reset is low.
    always_comb begin
        w_next_state   = r_state;
        w_busy         = (r_state != ST_IDLE);
        w_legal_start  = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = 4'd0;
        w_cnt_dec      = 1'b0;
        md_start       = 1'b0;
        mt_lo_we       = 1'b0;
        mt_hi_we       = 1'b0;
        hilo_we        = 1'b0;
        stall_d        = 1'b0;
        issue_err      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (reset && e_valid && !e_flush && is_start_op(e_op)) begin
                    w_legal_start = 1'b1;
                    if (is_mul_op(e_op)) begin
                        w_next_state   = ST_MUL_RUN;
                        w_cnt_load_val = MUL_LAT - 4'd1;
                    end else begin
                        w_next_state   = ST_DIV_RUN;
                        w_cnt_load_val = DIV_LAT - 4'd1;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        w_cnt_load = w_legal_start;
        w_cnt_dec  = w_busy && !w_cnt_zero;

        if (reset) begin
            md_start = w_legal_start;
            if ((r_state == ST_IDLE) && e_valid && !e_flush) begin
                mt_lo_we = (e_op == OP_MTLO);
                mt_hi_we = (e_op == OP_MTHI);
            end else begin
                mt_lo_we = 1'b0;
                mt_hi_we = 1'b0;
            end
            hilo_we   = w_busy && w_cnt_zero && !r_div_zero;
            stall_d   = d_uses_md && (w_busy || w_legal_start);
            issue_err = e_valid && ((e_op == OP_RSVD) || (w_busy && is_md_op(e_op)));
        end else begin
            md_start  = 1'b0;
            mt_lo_we  = 1'b0;
            mt_hi_we  = 1'b0;
            hilo_we   = 1'b0;
            stall_d   = 1'b0;
            issue_err = 1'b0;
        end
    end

    assign busy  = w_busy;
    assign md_op = r_md_op;
    assign cnt   = w_cnt;

endmodule
